// File: rtl/bcd_updown_counter_n.sv
// ----------------------------------------------------------------------------
// bcd_updown_counter_n
//   Multi-digit BCD up/down counter that counts 0..MOD_MAX. Supports
//   synchronous clear, parallel load with validity checking, and wrap or
//   saturate behaviour at the limits. Stages cascade by feeding co into
//   the ci of the next stage.
//
// Parameters
//   DIGITS   : number of BCD digits (1..6)
//   MOD_MAX  : largest count value, in decimal (1..10^DIGITS-1)
//   SATURATE : 0 = wrap at the limits, 1 = hold at the limits
//
// Ports
//   clk    : rising-edge clock
//   clr    : asynchronous active-high reset
//   en     : global enable; gates loading and counting
//   ci     : count enable from the lower cascade stage
//   ud     : direction, 1 = up, 0 = down
//   sclr   : synchronous clear; acts even when en is low
//   ld     : synchronous parallel load
//   d      : BCD load value, digit 0 at bits [3:0]
//   q      : BCD count value, digit 0 at bits [3:0]
//   tc     : terminal count for the current direction (combinational)
//   co     : cascade carry/borrow into the next stage (combinational)
//   sat    : high while held at a limit in saturate mode (registered)
//   ld_err : one-cycle pulse after a rejected load (registered)
// ----------------------------------------------------------------------------
module bcd_updown_counter_n #(
   parameter int DIGITS   = 2,
   parameter int MOD_MAX  = 99,
   parameter bit SATURATE = 1'b0
) (
   input  logic                  clk,
   input  logic                  clr,
   input  logic                  en,
   input  logic                  ci,
   input  logic                  ud,
   input  logic                  sclr,
   input  logic                  ld,
   input  logic [4*DIGITS-1:0]   d,
   output logic [4*DIGITS-1:0]   q,
   output logic                  tc,
   output logic                  co,
   output logic                  sat,
   output logic                  ld_err
);

   localparam int W = 4 * DIGITS;

   // Converts a decimal constant into its packed BCD form.
   function automatic logic [W-1:0] to_bcd(input int value);
      logic [W-1:0] r;
      int           rem;
      r   = '0;
      rem = value;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         r[4*i +: 4] = 4'(rem % 10);
         rem         = rem / 10;
      end
      return r;
   endfunction

   localparam logic [W-1:0] MAX_BCD = to_bcd(MOD_MAX);

   logic [W-1:0] q_inc;
   logic [W-1:0] q_dec;
   logic         carry;
   logic         borrow;
   logic         digits_ok;
   logic         load_ok;
   logic         at_limit;

   // All digit carries/borrows resolve within one cycle: a digit changes
   // only while every lower digit is rolling over.
   always_comb begin
      q_inc  = q;
      q_dec  = q;
      carry  = 1'b1;
      borrow = 1'b1;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         if (carry) begin
            if (q[4*i +: 4] == 4'd9) begin
               q_inc[4*i +: 4] = 4'd0;
            end else begin
               q_inc[4*i +: 4] = q[4*i +: 4] + 4'd1;
               carry           = 1'b0;
            end
         end
         if (borrow) begin
            if (q[4*i +: 4] == 4'd0) begin
               q_dec[4*i +: 4] = 4'd9;
            end else begin
               q_dec[4*i +: 4] = q[4*i +: 4] - 4'd1;
               borrow          = 1'b0;
            end
         end
      end
   end

   always_comb begin
      digits_ok = 1'b1;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         if (d[4*i +: 4] > 4'd9) digits_ok = 1'b0;
      end
   end

   // With every digit in 0..9, BCD ordering matches binary ordering, so a
   // plain unsigned compare against the BCD limit is a decimal compare.
   assign load_ok  = digits_ok && (d <= MAX_BCD);

   assign at_limit = ud ? (q == MAX_BCD) : (q == '0);
   assign tc       = at_limit;
   assign co       = tc & en & ci & ~ld & ~sclr & (SATURATE == 1'b0);

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         q      <= '0;
         sat    <= 1'b0;
         ld_err <= 1'b0;
      end else begin
         ld_err <= 1'b0;
         if (sclr) begin
            q   <= '0;
            sat <= 1'b0;
         end else if (en) begin
            if (ld) begin
               if (load_ok) begin
                  q   <= d;
                  sat <= 1'b0;
               end else begin
                  ld_err <= 1'b1;
               end
            end else if (ci) begin
               if (at_limit) begin
                  if (SATURATE) begin
                     sat <= 1'b1;
                  end else begin
                     q <= ud ? '0 : MAX_BCD;
                  end
               end else begin
                  q   <= ud ? q_inc : q_dec;
                  sat <= 1'b0;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_bcd_updown_counter_n.sv
module tb_bcd_updown_counter_n;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // ---------------- instance A: DIGITS=2, MOD_MAX=59, wrap ----------------
   logic       clr, en, ci, ud, sclr, ld;
   logic [7:0] d, q;
   logic       tc, co, sat, ld_err;

   bcd_updown_counter_n #(.DIGITS(2), .MOD_MAX(59), .SATURATE(1'b0)) dut_a (
      .clk(clk), .clr(clr), .en(en), .ci(ci), .ud(ud), .sclr(sclr), .ld(ld),
      .d(d), .q(q), .tc(tc), .co(co), .sat(sat), .ld_err(ld_err)
   );

   // ---------------- instance S: DIGITS=2, MOD_MAX=99, saturate ------------
   logic       s_clr, s_en, s_ci, s_ud, s_sclr, s_ld;
   logic [7:0] s_d, s_q;
   logic       s_tc, s_co, s_sat, s_ld_err;

   bcd_updown_counter_n #(.DIGITS(2), .MOD_MAX(99), .SATURATE(1'b1)) dut_s (
      .clk(clk), .clr(s_clr), .en(s_en), .ci(s_ci), .ud(s_ud), .sclr(s_sclr),
      .ld(s_ld), .d(s_d), .q(s_q), .tc(s_tc), .co(s_co), .sat(s_sat),
      .ld_err(s_ld_err)
   );

   // ---------------- cascade: ones (0..9) feeding tens (0..9) --------------
   logic       c_clr, c_en, c_ci, c_ud, c_sclr, c_ld;
   logic [3:0] c_d_one, c_d_ten, q_one, q_ten;
   logic       tc_one, co_one, sat_one, ld_err_one;
   logic       tc_ten, co_ten, sat_ten, ld_err_ten;

   bcd_updown_counter_n #(.DIGITS(1), .MOD_MAX(9), .SATURATE(1'b0)) dut_one (
      .clk(clk), .clr(c_clr), .en(c_en), .ci(c_ci), .ud(c_ud), .sclr(c_sclr),
      .ld(c_ld), .d(c_d_one), .q(q_one), .tc(tc_one), .co(co_one),
      .sat(sat_one), .ld_err(ld_err_one)
   );

   bcd_updown_counter_n #(.DIGITS(1), .MOD_MAX(9), .SATURATE(1'b0)) dut_ten (
      .clk(clk), .clr(c_clr), .en(c_en), .ci(co_one), .ud(c_ud), .sclr(c_sclr),
      .ld(c_ld), .d(c_d_ten), .q(q_ten), .tc(tc_ten), .co(co_ten),
      .sat(sat_ten), .ld_err(ld_err_ten)
   );

   // ---------------- behavioural reference model (decimal integers) --------
   int m_v;   bit m_s;   bit m_le;    // instance A
   int sm_v;  bit sm_s;  bit sm_le;   // instance S

   function automatic logic [23:0] int2bcd(input int v);
      logic [23:0] r;
      int          x;
      r = '0;
      x = v;
      for (int i = 0; i < 6; i++) begin
         r[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   function automatic int bcd2int(input logic [23:0] b, input int nd);
      int s, p;
      s = 0;
      p = 1;
      for (int i = 0; i < nd; i++) begin
         s = s + int'(b[4*i +: 4]) * p;
         p = p * 10;
      end
      return s;
   endfunction

   function automatic bit load_valid(input logic [23:0] b, input int nd, input int modmax);
      for (int i = 0; i < nd; i++)
         if (b[4*i +: 4] > 4'd9) return 1'b0;
      return bcd2int(b, nd) <= modmax;
   endfunction

   task automatic model_next(input int modmax, input bit satm, input logic s_c,
                             input logic e, input logic l, input logic c, input logic u,
                             input logic [23:0] dd, input int nd,
                             inout int v, inout bit s, output bit le);
      le = 1'b0;
      if (s_c) begin
         v = 0; s = 1'b0;
      end else if (e) begin
         if (l) begin
            if (load_valid(dd, nd, modmax)) begin
               v = bcd2int(dd, nd); s = 1'b0;
            end else begin
               le = 1'b1;
            end
         end else if (c) begin
            if (u) begin
               if (v == modmax) begin
                  if (satm) s = 1'b1; else v = 0;
               end else begin
                  v = v + 1; s = 1'b0;
               end
            end else begin
               if (v == 0) begin
                  if (satm) s = 1'b1; else v = modmax;
               end else begin
                  v = v - 1; s = 1'b0;
               end
            end
         end
      end
   endtask

   // Advance instance A model and clock by one edge; sample 1 ns after.
   task automatic step_a();
      model_next(59, 1'b0, sclr, en, ld, ci, ud, {16'h0, d}, 2, m_v, m_s, m_le);
      @(posedge clk);
      #1;
   endtask

   task automatic step_s();
      model_next(99, 1'b1, s_sclr, s_en, s_ld, s_ci, s_ud, {16'h0, s_d}, 2, sm_v, sm_s, sm_le);
      @(posedge clk);
      #1;
   endtask

   task automatic step_c();
      @(posedge clk);
      #1;
   endtask

   // ------------------------------------------------------------------------
   task automatic test_reset();
      logic [7:0] exp8;
      clr = 1'b1; en = 1'b1; ci = 1'b1; ud = 1'b1; sclr = 1'b0; ld = 1'b1; d = 8'h45;
      repeat (2) @(posedge clk);
      #1;
      exp8 = 8'h00;
      n_checks++;
      if (q !== exp8) begin n_fail++; $display("FAIL reset_q: got %h expected %h", q, exp8); end
      n_checks++;
      if (sat !== 1'b0) begin n_fail++; $display("FAIL reset_sat: got %b expected 0", sat); end
      n_checks++;
      if (ld_err !== 1'b0) begin n_fail++; $display("FAIL reset_ld_err: got %b expected 0", ld_err); end
      ld = 1'b0;
      clr = 1'b0;
      m_v = 0; m_s = 1'b0; m_le = 1'b0;
   endtask

   task automatic test_wrap_up();
      logic [23:0] e;
      bit exp_tc;
      clr = 1'b1; #2; clr = 1'b0;
      m_v = 0; m_s = 1'b0; m_le = 1'b0;
      en = 1'b1; ci = 1'b1; ud = 1'b1; ld = 1'b0; sclr = 1'b0;
      for (int i = 0; i < 60; i++) begin
         exp_tc = (i == 59);
         n_checks++;
         if (tc !== exp_tc || co !== exp_tc) begin
            n_fail++;
            $display("FAIL wrap_up_tc_co step %0d: got tc=%b co=%b expected %b", i, tc, co, exp_tc);
         end
         step_a();
         e = int2bcd((i + 1) % 60);
         n_checks++;
         if (q !== e[7:0]) begin n_fail++; $display("FAIL wrap_up_q step %0d: got %h expected %h", i, q, e[7:0]); end
      end
   endtask

   task automatic test_wrap_down();
      ud = 1'b0;
      #1;
      n_checks++;
      if (tc !== 1'b1 || co !== 1'b1) begin n_fail++; $display("FAIL wrap_down_tc_co: got tc=%b co=%b expected 1 1", tc, co); end
      step_a();
      n_checks++;
      if (q !== 8'h59) begin n_fail++; $display("FAIL wrap_down_q1: got %h expected 59", q); end
      step_a();
      n_checks++;
      if (q !== 8'h58) begin n_fail++; $display("FAIL wrap_down_q2: got %h expected 58", q); end
   endtask

   task automatic test_load();
      en = 1'b1; ci = 1'b1; ld = 1'b1; d = 8'h45;
      step_a();
      n_checks++;
      if (q !== 8'h45 || ld_err !== 1'b0) begin n_fail++; $display("FAIL load_valid: got q=%h ld_err=%b expected 45 0", q, ld_err); end
      d = 8'h60;
      step_a();
      n_checks++;
      if (q !== 8'h45 || ld_err !== 1'b1) begin n_fail++; $display("FAIL load_over_max: got q=%h ld_err=%b expected 45 1", q, ld_err); end
      ld = 1'b0; ci = 1'b0;
      step_a();
      n_checks++;
      if (q !== 8'h45 || ld_err !== 1'b0) begin n_fail++; $display("FAIL load_err_pulse: got q=%h ld_err=%b expected 45 0", q, ld_err); end
      ld = 1'b1; d = 8'h3A;
      step_a();
      n_checks++;
      if (q !== 8'h45 || ld_err !== 1'b1) begin n_fail++; $display("FAIL load_bad_digit: got q=%h ld_err=%b expected 45 1", q, ld_err); end
      en = 1'b0; d = 8'h12;
      step_a();
      n_checks++;
      if (q !== 8'h45 || ld_err !== 1'b0) begin n_fail++; $display("FAIL load_en_low: got q=%h ld_err=%b expected 45 0", q, ld_err); end
      en = 1'b1; ld = 1'b0; ci = 1'b1;
   endtask

   task automatic test_priority();
      en = 1'b1; ld = 1'b1; d = 8'h30;
      step_a();
      sclr = 1'b1; d = 8'h12;
      step_a();
      n_checks++;
      if (q !== 8'h00) begin n_fail++; $display("FAIL sclr_over_ld: got %h expected 00", q); end
      sclr = 1'b0; d = 8'h27;
      step_a();
      ld = 1'b0; ci = 1'b0;
      #1 clr = 1'b1;
      #1;
      n_checks++;
      if (q !== 8'h00) begin n_fail++; $display("FAIL async_clr: got %h expected 00", q); end
      clr = 1'b0;
      m_v = 0; m_s = 1'b0; m_le = 1'b0;
      ld = 1'b1; d = 8'h59;
      step_a();
      ld = 1'b0; en = 1'b0; ci = 1'b1; ud = 1'b1;
      #1;
      n_checks++;
      if (tc !== 1'b1 || co !== 1'b0) begin n_fail++; $display("FAIL en_low_co: got tc=%b co=%b expected 1 0", tc, co); end
      step_a();
      n_checks++;
      if (q !== 8'h59) begin n_fail++; $display("FAIL en_low_hold: got %h expected 59", q); end
      en = 1'b1;
   endtask

   task automatic test_random();
      logic [23:0] e;
      bit exp_tc, exp_co;
      for (int i = 0; i < 400; i++) begin
         en   = ($urandom_range(0, 7) != 0);
         ci   = ($urandom_range(0, 3) != 0);
         ud   = $urandom_range(0, 1);
         sclr = ($urandom_range(0, 24) == 0);
         ld   = ($urandom_range(0, 6) == 0);
         if ($urandom_range(0, 2) == 0) d = 8'($urandom_range(0, 255));
         else begin e = int2bcd($urandom_range(0, 59)); d = e[7:0]; end
         #1;
         exp_tc = ud ? (m_v == 59) : (m_v == 0);
         exp_co = exp_tc && en && ci && !ld && !sclr;
         n_checks++;
         if (tc !== exp_tc || co !== exp_co) begin
            n_fail++;
            $display("FAIL rand_tc_co %0d: got tc=%b co=%b expected %b %b", i, tc, co, exp_tc, exp_co);
         end
         step_a();
         e = int2bcd(m_v);
         n_checks++;
         if (q !== e[7:0] || sat !== m_s || ld_err !== m_le) begin
            n_fail++;
            $display("FAIL rand_state %0d: got q=%h sat=%b ld_err=%b expected %h %b %b",
                     i, q, sat, ld_err, e[7:0], m_s, m_le);
         end
      end
      sclr = 1'b0; ld = 1'b0;
   endtask

   task automatic test_saturate();
      logic [23:0] e;
      s_clr = 1'b1; s_en = 1'b1; s_ci = 1'b1; s_ud = 1'b1; s_sclr = 1'b0; s_ld = 1'b0; s_d = 8'h00;
      #2 s_clr = 1'b0;
      sm_v = 0; sm_s = 1'b0; sm_le = 1'b0;
      s_ld = 1'b1; s_d = 8'h98;
      step_s();
      s_ld = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         n_checks++;
         if (s_co !== 1'b0) begin n_fail++; $display("FAIL sat_co step %0d: got %b expected 0", i, s_co); end
         step_s();
         n_checks++;
         if (s_q !== 8'h99 || s_sat !== (i >= 2)) begin
            n_fail++;
            $display("FAIL sat_up step %0d: got q=%h sat=%b expected 99 %b", i, s_q, s_sat, (i >= 2));
         end
      end
      s_ud = 1'b0;
      step_s();
      n_checks++;
      if (s_q !== 8'h98 || s_sat !== 1'b0) begin n_fail++; $display("FAIL sat_leave: got q=%h sat=%b expected 98 0", s_q, s_sat); end
      s_ld = 1'b1; s_d = 8'h01;
      step_s();
      s_ld = 1'b0;
      repeat (2) step_s();
      n_checks++;
      if (s_q !== 8'h00 || s_sat !== 1'b1) begin n_fail++; $display("FAIL sat_down: got q=%h sat=%b expected 00 1", s_q, s_sat); end
      for (int i = 0; i < 300; i++) begin
         s_en   = ($urandom_range(0, 7) != 0);
         s_ci   = ($urandom_range(0, 3) != 0);
         s_ud   = ($urandom_range(0, 3) != 0) ? s_ud : ~s_ud;
         s_sclr = ($urandom_range(0, 29) == 0);
         s_ld   = ($urandom_range(0, 9) == 0);
         if ($urandom_range(0, 2) == 0) s_d = 8'($urandom_range(0, 255));
         else begin e = int2bcd($urandom_range(0, 99)); s_d = e[7:0]; end
         #1;
         n_checks++;
         if (s_co !== 1'b0 || s_tc !== (s_ud ? (sm_v == 99) : (sm_v == 0))) begin
            n_fail++;
            $display("FAIL sat_rand_tc_co %0d: got tc=%b co=%b", i, s_tc, s_co);
         end
         step_s();
         e = int2bcd(sm_v);
         n_checks++;
         if (s_q !== e[7:0] || s_sat !== sm_s || s_ld_err !== sm_le) begin
            n_fail++;
            $display("FAIL sat_rand_state %0d: got q=%h sat=%b ld_err=%b expected %h %b %b",
                     i, s_q, s_sat, s_ld_err, e[7:0], sm_s, sm_le);
         end
      end
   endtask

   task automatic test_cascade();
      c_clr = 1'b1; c_en = 1'b1; c_ci = 1'b1; c_ud = 1'b1; c_sclr = 1'b0; c_ld = 1'b0;
      c_d_one = 4'd0; c_d_ten = 4'd0;
      #2 c_clr = 1'b0;
      for (int k = 1; k <= 39; k++) begin
         n_checks++;
         if (co_one !== ((k - 1) % 10 == 9)) begin
            n_fail++;
            $display("FAIL cascade_co count %0d: got %b expected %b", k - 1, co_one, ((k - 1) % 10 == 9));
         end
         step_c();
         n_checks++;
         if (q_one !== 4'(k % 10) || q_ten !== 4'(k / 10)) begin
            n_fail++;
            $display("FAIL cascade_up %0d: got %h%h expected %0d", k, q_ten, q_one, k);
         end
      end
      c_ld = 1'b1; c_d_one = 4'd0; c_d_ten = 4'd3;
      step_c();
      c_ld = 1'b0; c_ud = 1'b0;
      #1;
      n_checks++;
      if (co_one !== 1'b1) begin n_fail++; $display("FAIL cascade_borrow_co: got %b expected 1", co_one); end
      step_c();
      n_checks++;
      if (q_one !== 4'd9 || q_ten !== 4'd2) begin
         n_fail++;
         $display("FAIL cascade_down: got tens=%0d ones=%0d expected 2 9", q_ten, q_one);
      end
   endtask

   initial begin
      s_clr = 1'b1; s_en = 1'b0; s_ci = 1'b0; s_ud = 1'b1; s_sclr = 1'b0; s_ld = 1'b0; s_d = 8'h00;
      c_clr = 1'b1; c_en = 1'b0; c_ci = 1'b0; c_ud = 1'b1; c_sclr = 1'b0; c_ld = 1'b0;
      c_d_one = 4'd0; c_d_ten = 4'd0;
      test_reset();
      test_wrap_up();
      test_wrap_down();
      test_load();
      test_priority();
      test_random();
      test_saturate();
      test_cascade();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/bcd_updown_counter_n.md
Name: bcd_updown_counter_n

Overview:
- Parametrised multi-digit BCD up/down counter with modulo limit, parallel load, wrap/saturate mode and cascade carry in/out.
- Generalises the single-digit decade up/down counter to DIGITS BCD digits, counting 0..MOD_MAX, e.g. 0..59 for clock minutes/seconds.
- Sits in the timer/clock display datapath. Feeds seven-segment decoders and chains to further counters via ci/co.

Parameters:
- DIGITS, 2, number of BCD digits; 1 to 6.
- MOD_MAX, 99, maximum count value in decimal. Must satisfy 1 <= MOD_MAX <= 10^DIGITS-1.
- SATURATE, 0, 0 = wrap at limits; 1 = hold at limits.

Ports:
- clk  in  1  rising-edge clock.
- clr  in  1  asynchronous active-high reset.
- en  in  1  global enable; gates ld and counting.
- ci  in  1  count enable from lower cascade stage; tie to 1 when unused.
- ud  in  1  1 = count up, 0 = count down.
- sclr  in  1  synchronous clear to 0.
- ld  in  1  synchronous parallel load.
- d  in  4*DIGITS  BCD load value; digit 0 at bits [3:0].
- q  out  4*DIGITS  BCD count value; digit 0 at bits [3:0].
- tc  out  1  terminal count, combinational. Up: q==MOD_MAX. Down: q==0.
- co  out  1  cascade carry/borrow, combinational: tc & en & ci & ~ld & ~sclr & (SATURATE==0).
- sat  out  1  registered; 1 while held at a limit in SATURATE mode.
- ld_err  out  1  registered one-cycle pulse on a rejected load.

Behaviour:
- Reset (clr=1, asynchronous, overrides everything): q=0, sat=0, ld_err=0. These values hold while clr=1.
- Priority at each rising clk edge, highest first:
  1. sclr=1: q=0, sat=0. Acts regardless of en.
  2. en=0: q and sat hold.
  3. ld=1: load d if d is valid. ci is ignored for loads.
  4. ci=1: count one step in the direction given by ud.
  5. Otherwise: hold.
- ld_err defaults to 0 every cycle. It is 1 only in the cycle after a rejected load.
- Load validity: every digit of d must be <= 9 and the decimal value of d must be <= MOD_MAX.
  - Valid load: q=d, sat=0.
  - Invalid load: q unchanged, ld_err=1 for exactly one cycle.
- Counting is decimal per digit:
  - Up: digit 9 rolls to 0 and carries into the next digit.
  - Down: digit 0 rolls to 9 and borrows from the next digit.
  - Digit carries are internal and all take effect in the same cycle. No ripple latency is visible on q.
- Up at MOD_MAX:
  - SATURATE=0: q becomes 0.
  - SATURATE=1: q holds, sat=1.
- Down at 0:
  - SATURATE=0: q becomes MOD_MAX.
  - SATURATE=1: q holds, sat=1.
- sat clears on any successful count step away from the limit, on a valid load, or on sclr.
- A ud change takes effect on the next counting edge. tc follows ud combinationally in the same cycle.
- co is intended as ci of the next stage. It is asserted in the same cycle that this stage wraps, so the next stage steps on the same edge.
- Latency: q updates one clock after qualifying inputs. tc and co are zero-latency combinational.
- An out-of-range q cannot be reached from reset, load or counting. No recovery logic is required.
- A clr assertion mid-count takes effect immediately, without waiting for a clock edge.

Test Plan (DIGITS=2, MOD_MAX=59 unless noted):
- Wrap up: clr pulse; en=1, ci=1, ud=1 for 60 clocks. q steps 00,01..09,10..59 then 00. tc=co=1 only in the cycle q=59.
- Wrap down: q=00, ud=0, en=ci=1, one clock. Before the edge tc=co=1; after it q=59. Next clock gives q=58.
- Load checks:
  - ld=1, d=0x45 gives q=45, ld_err=0.
  - d=0x60 (>MOD_MAX) keeps q=45, ld_err=1 for one cycle.
  - d=0x3A (digit >9) keeps q, ld_err=1.
  - ld=1 with en=0 gives no change, ld_err=0.
- Priority and clears:
  - At q=30, assert sclr and ld (d=0x12) together: q=00.
  - Assert clr between edges: q=00 immediately.
  - With en=0 and ci=1: q holds and co=0.
- Saturate (SATURATE=1, MOD_MAX=99):
  - Load 98, count up 3 clocks: q=99, sat=1 from the 2nd edge, co stays 0.
  - Then ud=0, one clock: q=98, sat=0.
- Cascade: two instances, ones stage (DIGITS=1, MOD_MAX=9) co feeding tens stage ci.
  - Count 0 to 39 over 39 clocks; the tens stage increments exactly on the edges where ones wraps 9 to 0.
  - With ud=0 from tens=3, ones=0: ones=9 and tens=2 after one clock.
